// File: rtl/cva6_lsu_pkg.sv
// ---------------------------------------------------------------------------
// cva6_lsu_pkg
// Shared definitions for the CVA6 data-RAM initiator (cva6_lsu_ram_master)
// and its lane-alignment helper (cva6_lsu_align).
//   - access-size encodings carried on req_size
//   - FSM state enumeration
//   - default RAM window parameters
//   - helper that aligns a byte offset down to the access size
// ---------------------------------------------------------------------------
package cva6_lsu_pkg;

    // Access-size encodings on req_size
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    // Default data-RAM window
    localparam logic [31:0] DEF_BASE_ADDR  = 32'h1000_0000;
    localparam int          DEF_SIZE_BYTES = 4096;
    localparam int          DEF_MEM_AW     = 12;

    // Request sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } lsu_state_e;

    // Clear the low address bits that lie below the access size, so a
    // misaligned half/word is turned into the naturally aligned access
    // that contains its first byte.
    function automatic logic [1:0] align_offset(input logic [1:0] size,
                                                input logic [1:0] off);
        logic [1:0] res;
        res = off;
        if (size == SZ_H) begin
            res[0] = 1'b0;
        end else if (size == SZ_W) begin
            res = 2'b00;
        end
        return res;
    endfunction

endpackage

// File: rtl/cva6_lsu_align.sv
// ---------------------------------------------------------------------------
// cva6_lsu_align
// Purely combinational byte-lane logic for the data-RAM initiator.
// Store side: builds byte enables and replicates right-aligned store data
// onto every lane so the RAM picks the correct bytes via the enables.
// Load side: shifts the addressed lane of the RAM word down to bit 0 and
// sign- or zero-extends it according to the access size.
// Ports
//   st_size   in  2   store/request access size
//   st_off    in  2   byte offset inside the word (already aligned)
//   st_data   in  32  right-aligned store data
//   st_be     out 4   byte enables
//   st_lanes  out 32  lane-replicated write data
//   ld_size   in  2   latched load size
//   ld_off    in  2   latched byte offset
//   ld_unsigned in 1  zero-extend (1) or sign-extend (0)
//   ld_raw    in  32  raw RAM read word
//   ld_data   out 32  extracted and extended load result
// ---------------------------------------------------------------------------
module cva6_lsu_align
    import cva6_lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_lanes,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Store lanes: the illegal size never reaches the RAM, so it simply
    // produces no enables.
    always_comb begin
        st_be    = 4'b0000;
        st_lanes = st_data;
        case (st_size)
            SZ_B: begin
                st_be    = 4'b0001 << st_off;
                st_lanes = {4{st_data[7:0]}};
            end
            SZ_H: begin
                st_be    = 4'b0011 << st_off;
                st_lanes = {2{st_data[15:0]}};
            end
            SZ_W: begin
                st_be    = 4'b1111;
                st_lanes = st_data;
            end
            default: begin
                st_be    = 4'b0000;
                st_lanes = st_data;
            end
        endcase
    end

    // Load extract: word loads are returned as-is regardless of ld_unsigned.
    always_comb begin
        shifted = ld_raw >> {ld_off, 3'b000};
        ld_data = ld_raw;
        case (ld_size)
            SZ_B: ld_data = ld_unsigned ? {24'h00_0000, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H: ld_data = ld_unsigned ? {16'h0000, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_data = ld_raw;
        endcase
    end

endmodule

// File: rtl/cva6_lsu_ram_master.sv
// ---------------------------------------------------------------------------
// cva6_lsu_ram_master
// Initiator side of the CVA6 data-RAM port. Takes one load/store at a time
// from the core, checks window range, size and (optionally) alignment,
// issues a single-cycle access to a synchronous RAM and returns either a
// sign/zero-extended load result or a store acknowledge.
//
// Build option: define CVA6_LSU_MISALIGN_EXC_EN to report misaligned
// half/word accesses as errors. Without it, such accesses are silently
// aligned down and performed.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            core request handshake
//   req_we, req_addr, req_size,
//   req_unsigned, req_wdata        request payload
//   resp_valid/resp_ready          core response handshake
//   resp_rdata, resp_err           response payload
//   mem_req, mem_we, mem_be,
//   mem_addr, mem_wdata            RAM command (registered)
//   mem_rdata                      RAM read data, one cycle after mem_req
// ---------------------------------------------------------------------------
module cva6_lsu_ram_master
    import cva6_lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          SIZE_BYTES = DEF_SIZE_BYTES,
    parameter int          MEM_AW     = DEF_MEM_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int OFF_W = $clog2(SIZE_BYTES);

    lsu_state_e        state;
    lsu_state_e        next_state;

    logic [31:0]       offset;
    logic              in_range;
    logic              size_bad;
    logic              req_err;
    logic              accept;
    logic [1:0]        eff_off;
    logic [MEM_AW-1:0] word_addr;

    logic              lat_we;
    logic [1:0]        lat_size;
    logic              lat_unsigned;
    logic [1:0]        lat_off;
    logic              lat_err;

    logic [3:0]        st_be;
    logic [31:0]       st_lanes;
    logic [31:0]       ld_data;

    logic [31:0]       rdata_hold;
    logic              hold_valid;

    // Request decode: window check uses the unsigned byte offset from the
    // base, and the address below the base is caught explicitly so a
    // wrapped subtraction can never look in range.
    assign offset    = req_addr - BASE_ADDR;
    assign in_range  = (req_addr >= BASE_ADDR) && (offset < 32'(SIZE_BYTES));
    assign size_bad  = (req_size == SZ_X);
    assign word_addr = MEM_AW'(offset[OFF_W-1:2]);
    assign accept    = (state == ST_IDLE) && req_ready && req_valid;

`ifdef CVA6_LSU_MISALIGN_EXC_EN
    logic misaligned;
    assign misaligned = ((req_size == SZ_H) && req_addr[0]) ||
                        ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
    assign req_err    = !in_range || size_bad || misaligned;
    assign eff_off    = req_addr[1:0];
`else
    assign req_err    = !in_range || size_bad;
    assign eff_off    = align_offset(req_size, req_addr[1:0]);
`endif

    cva6_lsu_align u_align (
        .st_size     (req_size),
        .st_off      (eff_off),
        .st_data     (req_wdata),
        .st_be       (st_be),
        .st_lanes    (st_lanes),
        .ld_size     (lat_size),
        .ld_off      (lat_off),
        .ld_unsigned (lat_unsigned),
        .ld_raw      (mem_rdata),
        .ld_data     (ld_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: errors skip the RAM and go straight to the response
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = req_err ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: next_state = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Registered handshake, RAM command and latched request fields
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_be       <= 4'b0000;
            mem_addr     <= '0;
            mem_wdata    <= 32'h0000_0000;
            lat_we       <= 1'b0;
            lat_size     <= SZ_B;
            lat_unsigned <= 1'b0;
            lat_off      <= 2'b00;
            lat_err      <= 1'b0;
            rdata_hold   <= 32'h0000_0000;
            hold_valid   <= 1'b0;
        end else begin
            req_ready  <= (next_state == ST_IDLE);
            resp_valid <= (next_state == ST_RESP);
            resp_err   <= (next_state == ST_RESP) && (accept ? req_err : lat_err);
            hold_valid <= (state == ST_RESP) && (next_state == ST_RESP);

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_we       <= req_we;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_off      <= eff_off;
                        lat_err      <= req_err;
                        if (!req_err) begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_be    <= st_be;
                            mem_addr  <= word_addr;
                            mem_wdata <= st_lanes;
                        end
                    end
                end
                ST_ISSUE: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    mem_be  <= 4'b0000;
                end
                ST_RESP: begin
                    if (!hold_valid) begin
                        rdata_hold <= ld_data;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // RAM data only exists during the first response cycle, so that cycle
    // passes the extracted value straight through while it is captured;
    // later cycles of a stalled response replay the captured copy.
    assign resp_rdata = (resp_valid && !lat_we && !lat_err)
                        ? (hold_valid ? rdata_hold : ld_data)
                        : 32'h0000_0000;

endmodule

// File: tb/tb_cva6_lsu_ram_master.sv
// ---------------------------------------------------------------------------
// tb_cva6_lsu_ram_master
// Self-checking bench for cva6_lsu_ram_master with a behavioural
// synchronous RAM. Expected responses are queued when a request is driven
// and compared when the response handshake happens.
// ---------------------------------------------------------------------------
module tb_cva6_lsu_ram_master;
    import cva6_lsu_pkg::*;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        preload;
    logic [31:0] ram     [0:1023];
    logic [31:0] ref_mem [0:1023];
    exp_t        sb [$];
    exp_t        sb_head;
    int          checks   = 0;
    int          failures = 0;
    int          mreq_total = 0;

    always #5 clk = ~clk;

    cva6_lsu_ram_master dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    function automatic logic [31:0] pattern(input int i);
        if (i == 4) return 32'h8012_3456;
        return {8'(i) ^ 8'h5A, 8'(i), 8'hC3, 8'(i)};
    endfunction

    // Synchronous RAM; read data is scrambled on idle cycles so anything
    // that samples it late sees garbage.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) ram[i] <= pattern(i);
        end else if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[9:0]];
            end
        end else begin
            mem_rdata <= mem_rdata ^ 32'hFFFF_FFFF;
        end
    end

    always @(posedge clk) begin
        if (mem_req) mreq_total <= mreq_total + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Response scoreboard
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            checkOutput("sb_nonempty", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) begin
                sb_head = sb.pop_front();
                checkOutput("resp_err", {31'd0, resp_err}, {31'd0, sb_head.err});
                checkOutput("resp_rdata", resp_rdata, sb_head.rdata);
            end
        end
    end

    // Reference model of one request against the shadow memory
    task automatic modelRequest(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wd,
                                output logic err, output logic [9:0] idx, output logic [3:0] be,
                                output logic [31:0] mwd, output logic [31:0] rd);
        logic [31:0] off;
        logic [31:0] w;
        logic [31:0] sh;
        logic [1:0]  lo;
        off = addr - 32'h1000_0000;
        err = (addr < 32'h1000_0000) || (off >= 32'd4096) || (size == 2'b11);
`ifdef CVA6_LSU_MISALIGN_EXC_EN
        if (size == 2'b01 && addr[0]) err = 1'b1;
        if (size == 2'b10 && addr[1:0] != 2'b00) err = 1'b1;
`endif
        idx = off[11:2];
        lo  = addr[1:0];
        if (size == 2'b01) lo[0] = 1'b0;
        else if (size == 2'b10) lo = 2'b00;
        case (size)
            2'b00:   begin be = 4'b0001 << lo; mwd = {4{wd[7:0]}};  end
            2'b01:   begin be = 4'b0011 << lo; mwd = {2{wd[15:0]}}; end
            default: begin be = 4'b1111;       mwd = wd;            end
        endcase
        rd = 32'h0;
        if (!err && !we) begin
            w  = ref_mem[idx];
            sh = w >> (8 * lo);
            case (size)
                2'b00:   rd = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
                2'b01:   rd = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
                default: rd = w;
            endcase
        end
        if (!err && we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[idx][8*b +: 8] = mwd[8*b +: 8];
        end
    endtask

    // Drive one request, check the RAM command, latency and stall behaviour.
    // Called at posedge+1.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wd, input int hold,
                                 input string tag);
        logic        e_err;
        logic [9:0]  e_idx;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        logic [31:0] first;
        int          n;
        int          lat;
        int          mstart;
        modelRequest(we, addr, size, uns, wd, e_err, e_idx, e_be, e_wd, e_rd);
        sb.push_back({e_err, e_rd});
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checkOutput({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wd;
        mstart = mreq_total;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!e_err) begin
            checkOutput({tag, "_mem_req"},  {31'd0, mem_req}, 32'd1);
            checkOutput({tag, "_mem_we"},   {31'd0, mem_we},  {31'd0, we});
            checkOutput({tag, "_mem_be"},   {28'd0, mem_be},  {28'd0, e_be});
            checkOutput({tag, "_mem_addr"}, {20'd0, mem_addr}, {22'd0, e_idx});
            if (we) checkOutput({tag, "_mem_wdata"}, mem_wdata, e_wd);
        end else begin
            checkOutput({tag, "_mem_req_err"}, {31'd0, mem_req}, 32'd0);
        end
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), e_err ? 32'd1 : 32'd2);
        checkOutput({tag, "_mem_pulses"}, 32'(mreq_total - mstart), e_err ? 32'd0 : 32'd1);
        first = resp_rdata;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            checkOutput({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
            checkOutput({tag, "_hold_rdata"}, resp_rdata, first);
            checkOutput({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
            checkOutput({tag, "_hold_memreq"}, {31'd0, mem_req}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput({tag, "_resp_drop"}, {31'd0, resp_valid}, 32'd0);
    endtask

    // Assert reset while the RAM access is in flight; no response may follow.
    task automatic resetMidIssue(input logic [31:0] addr);
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_size = SZ_W;
        req_unsigned = 1'b0; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("rst_issue_memreq", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("rst_issue_valid", {31'd0, resp_valid}, 32'd0);
            checkOutput("rst_issue_mreq",  {31'd0, mem_req},    32'd0);
            checkOutput("rst_issue_ready", {31'd0, req_ready},  32'd0);
        end
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("post_rst_valid", {31'd0, resp_valid}, 32'd0);
            checkOutput("post_rst_ready", {31'd0, req_ready},  32'd1);
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout got=running exp=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] a;
        rst = 1'b1; preload = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 32'h0; req_size = SZ_B; req_unsigned = 1'b0; req_wdata = 32'h0;
        resp_ready = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = pattern(i);
        @(posedge clk); #1;
        preload = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("rst_req_ready",  {31'd0, req_ready},  32'd0);
            checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
            checkOutput("rst_resp_err",   {31'd0, resp_err},   32'd0);
            checkOutput("rst_resp_rdata", resp_rdata,          32'd0);
            checkOutput("rst_mem_req",    {31'd0, mem_req},    32'd0);
            checkOutput("rst_mem_we",     {31'd0, mem_we},     32'd0);
            checkOutput("rst_mem_be",     {28'd0, mem_be},     32'd0);
            checkOutput("rst_mem_addr",   {20'd0, mem_addr},   32'd0);
            checkOutput("rst_mem_wdata",  mem_wdata,           32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("ready_after_rst", {31'd0, req_ready}, 32'd1);

        applyStimulus(1'b0, 32'h1000_0013, SZ_B, 1'b0, 32'h0, 0, "ld_b_s");
        applyStimulus(1'b0, 32'h1000_0013, SZ_B, 1'b1, 32'h0, 0, "ld_b_u");
        applyStimulus(1'b0, 32'h1000_0012, SZ_H, 1'b0, 32'h0, 0, "ld_h_s");
        applyStimulus(1'b1, 32'h1000_0010, SZ_W, 1'b0, 32'hDEAD_BEEF, 0, "st_w");
        applyStimulus(1'b0, 32'h1000_0010, SZ_W, 1'b1, 32'h0, 0, "ld_w");
        applyStimulus(1'b1, 32'h1000_0006, SZ_H, 1'b0, 32'hAAAA_1234, 0, "st_h");
        applyStimulus(1'b0, 32'h1000_0006, SZ_H, 1'b1, 32'h0, 0, "ld_h_u");
        applyStimulus(1'b0, 32'h1000_0006, SZ_H, 1'b0, 32'h0, 0, "ld_h_s2");
        applyStimulus(1'b0, 32'h1000_1000, SZ_W, 1'b0, 32'h0, 0, "err_hi");
        applyStimulus(1'b1, 32'h0FFF_FFFC, SZ_W, 1'b0, 32'h1111_2222, 0, "err_lo");
        applyStimulus(1'b1, 32'h1000_0000, SZ_X, 1'b0, 32'h3333_4444, 0, "err_size");
        applyStimulus(1'b0, 32'h1000_0000, SZ_W, 1'b0, 32'h0, 0, "ld_w0");
        applyStimulus(1'b0, 32'h1000_0002, SZ_W, 1'b0, 32'h0, 0, "mis_w");
        applyStimulus(1'b0, 32'h1000_0013, SZ_H, 1'b0, 32'h0, 0, "mis_h");
        applyStimulus(1'b1, 32'h1000_0FFF, SZ_B, 1'b0, 32'h0000_00A5, 0, "st_b_last");
        applyStimulus(1'b0, 32'h1000_0FFF, SZ_B, 1'b0, 32'h0, 0, "ld_b_last");
        applyStimulus(1'b0, 32'h1000_0FFC, SZ_W, 1'b0, 32'h0, 0, "ld_w_last");
        applyStimulus(1'b0, 32'h1000_0010, SZ_W, 1'b0, 32'h0, 5, "ld_hold");
        applyStimulus(1'b1, 32'h1000_0020, SZ_W, 1'b0, 32'h0BAD_F00D, 3, "st_hold");
        applyStimulus(1'b0, 32'h1000_0013, SZ_B, 1'b1, 32'h0, 4, "ld_b_hold");

        resetMidIssue(32'h1000_0040);
        applyStimulus(1'b0, 32'h1000_0040, SZ_W, 1'b0, 32'h0, 0, "ld_after_rst");

        for (int i = 0; i < 40; i++) begin
            a = 32'h0FFF_FF00 + 32'($urandom_range(0, 4400));
            applyStimulus(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2), "rnd");
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
